// File: rtl/mux_share_pkg.sv
// mux_share_pkg: shared types, constants and round-robin pick helper
package mux_share_pkg;
    localparam int NUM_REQ = 4;
    localparam int SEL_W = 2;
    typedef enum logic {IDLE, GRANT} state_t;
    function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [SEL_W-1:0] start);
        logic [SEL_W:0] r;
        logic [SEL_W-1:0] idx;
        r = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = start + SEL_W'(k);
            if (req[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first set request scanning upward from start with wrap
module rr_priority_picker
    import mux_share_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   start,
    output logic [NUM_REQ-1:0] win,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);
    // nearest requester at or after start wins
    always_comb begin
        {any, idx} = rr_pick(req, start);
        win = any ? NUM_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: round-robin arbiter sharing one muxed output path with bounded tenure
module mux_share_arbiter
    import mux_share_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int DATA_W = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   din,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [SEL_W-1:0]            sel,
    output logic [DATA_W-1:0]           dout,
    output logic                        dout_valid
);
    localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [SEL_W-1:0] last, last_n, sel_n, start, idx;
    logic [NUM_REQ-1:0] gnt_n, win;
    logic any, done;

    rr_priority_picker u_pick (.req(req), .start(start), .win(win), .idx(idx), .any(any));

    // tenure end detection, re-arbitration and hold countdown
    always_comb begin
        done = state == GRANT && (!req[sel] || cnt == '0);
        start = (state == GRANT ? sel : last) + 1'b1;
        state_n = state;
        gnt_n = gnt;
        sel_n = sel;
        cnt_n = cnt;
        last_n = last;
        if (state == IDLE || done) begin
            last_n = done ? sel : last;
            state_n = any ? GRANT : IDLE;
            gnt_n = win;
            sel_n = any ? idx : sel;
            cnt_n = any ? CW'(HOLD_CYCLES - 1) : cnt;
        end else begin
            cnt_n = cnt - 1'b1;
        end
    end

    // arbiter state; last resets to 3 so requester 0 goes first
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt <= '0;
            sel <= '0;
            cnt <= '0;
            last <= SEL_W'(NUM_REQ - 1);
        end else begin
            state <= state_n;
            gnt <= gnt_n;
            sel <= sel_n;
            cnt <= cnt_n;
            last <= last_n;
        end
    end

    // output mux driven by the registered select, one cycle behind the grant
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout <= din[DATA_W*int'(sel) +: DATA_W];
            dout_valid <= |gnt;
        end
    end
endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb_mux_share_arbiter: directed checks of grant order, tenure, latency and reset
module tb_mux_share_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] req4 = '0, req2 = '0, req1 = '0;
    logic [15:0] din4 = '0, din2 = '0, din1 = '0;
    logic [3:0] gnt4, gnt2, gnt1, dout4, dout2, dout1;
    logic [1:0] sel4, sel2, sel1;
    logic v4, v2, v1;
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mux_share_arbiter #(.HOLD_CYCLES(4), .DATA_W(4)) u4 (.clk(clk), .reset(reset), .req(req4), .din(din4),
        .gnt(gnt4), .sel(sel4), .dout(dout4), .dout_valid(v4));
    mux_share_arbiter #(.HOLD_CYCLES(2), .DATA_W(4)) u2 (.clk(clk), .reset(reset), .req(req2), .din(din2),
        .gnt(gnt2), .sel(sel2), .dout(dout2), .dout_valid(v2));
    mux_share_arbiter #(.HOLD_CYCLES(1), .DATA_W(4)) u1 (.clk(clk), .reset(reset), .req(req1), .din(din1),
        .gnt(gnt1), .sel(sel1), .dout(dout1), .dout_valid(v1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] ord2 [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
        logic [3:0] dat2 [8] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4};
        logic [3:0] ord1 [5] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001};
        tick();
        tick();
        chk("rst_gnt", gnt4, 0);
        chk("rst_sel", sel4, 0);
        chk("rst_dout", dout4, 0);
        chk("rst_valid", v4, 0);
        reset = 1'b0;
        req4 = 4'b0001;
        din4 = 16'h00BA;
        tick();
        chk("a_gnt_e1", gnt4, 4'b0001);
        chk("a_sel_e1", sel4, 0);
        chk("a_valid_e1", v4, 0);
        for (int e = 2; e <= 6; e++) begin
            tick();
            chk($sformatf("a_gnt_e%0d", e), gnt4, 4'b0001);
            chk($sformatf("a_dout_e%0d", e), dout4, 4'hA);
            chk($sformatf("a_valid_e%0d", e), v4, 1);
        end
        req4 = 4'b0011;
        tick();
        chk("a_gnt_e7", gnt4, 4'b0001);
        tick();
        chk("a_gnt_e8", gnt4, 4'b0001);
        tick();
        chk("a_expire_gnt", gnt4, 4'b0010);
        chk("a_expire_sel", sel4, 1);
        req4 = 4'b0110;
        tick();
        chk("b_hold_gnt", gnt4, 4'b0010);
        reset = 1'b1;
        tick();
        chk("b_rst_gnt", gnt4, 0);
        chk("b_rst_sel", sel4, 0);
        chk("b_rst_dout", dout4, 0);
        chk("b_rst_valid", v4, 0);
        reset = 1'b0;
        tick();
        chk("b_first_gnt", gnt4, 4'b0010);
        chk("b_first_sel", sel4, 1);
        chk("b_first_valid", v4, 0);
        tick();
        chk("b_dout", dout4, 4'hB);
        chk("b_valid", v4, 1);
        req4 = 4'b0000;
        tick();
        chk("c_gnt_drop", gnt4, 0);
        chk("c_valid_lag", v4, 1);
        chk("c_sel_hold", sel4, 1);
        tick();
        chk("c_valid_low", v4, 0);
        chk("c_dout_hold", dout4, 4'hB);
        chk("c_sel_hold2", sel4, 1);
        req2 = 4'b1111;
        din2 = 16'h4321;
        tick();
        chk("d_gnt_0", gnt2, ord2[0]);
        for (int i = 1; i < 9; i++) begin
            tick();
            chk($sformatf("d_gnt_%0d", i), gnt2, ord2[i]);
            chk($sformatf("d_dout_%0d", i), dout2, dat2[i-1]);
        end
        req2 = 4'b0100;
        tick();
        chk("d_drop_g2", gnt2, 4'b0100);
        chk("d_drop_v10", v2, 1);
        req2 = 4'b1000;
        tick();
        chk("d_drop_g3", gnt2, 4'b1000);
        chk("d_drop_v11", v2, 1);
        tick();
        chk("d_drop_v12", v2, 1);
        chk("d_drop_dout", dout2, 4'h4);
        req2 = 4'b0000;
        req1 = 4'b0101;
        din1 = 16'h0C0D;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("e_gnt_%0d", i), gnt1, ord1[i]);
            chk($sformatf("e_onehot_%0d", i), 32'($onehot0(gnt1)), 1);
            chk($sformatf("e_sel_%0d", i), sel1, (i % 2 == 1) ? 2 : 0);
            if (i > 0) chk($sformatf("e_dout_%0d", i), dout1, (i % 2 == 1) ? 4'hD : 4'hC);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
